// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM generator.
package pwm_pkg;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    // Write-index width; a single channel still gets a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Moves act toward target by at most step (step 0 jumps straight there).
    // The difference is taken one bit wider so it can never wrap.
    function automatic logic [31:0] sat_step(input logic [31:0] act,
                                             input logic [31:0] target,
                                             input logic [31:0] step);
        logic [32:0] diff;
        if (step == 32'd0) begin
            return target;
        end
        if (target >= act) begin
            diff = {1'b0, target} - {1'b0, act};
            return (diff <= {1'b0, step}) ? target : act + step;
        end
        diff = {1'b0, act} - {1'b0, target};
        return (diff <= {1'b0, step}) ? target : act - step;
    endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: target/active duty, ramp at the period boundary,
// registered compare output with polarity, and settled flag.
module pwm_chan
    import pwm_pkg::*;
#(
    parameter int         WIDTH     = 16,
    parameter int         RAMP_STEP = 0,
    parameter logic       POLARITY  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pb_i,
    input  logic [WIDTH-1:0] cnt_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_duty_i,
    output logic             pwm_o,
    output logic             settled_o
);

    logic [WIDTH-1:0] target_q, act_q, act_d;
    logic             pwm_q, settled_q;

    always_comb begin
        act_d = WIDTH'(sat_step(32'(act_q), 32'(target_q), 32'(RAMP_STEP)));
    end

    // act only moves at the boundary, so a period never sees a runt pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            target_q  <= '0;
            act_q     <= '0;
            pwm_q     <= POLARITY;
            settled_q <= 1'b1;
        end else begin
            if (wr_en_i) begin
                target_q <= wr_duty_i;
            end
            if (pb_i) begin
                act_q <= act_d;
            end
            pwm_q     <= (cnt_i < act_q) ^ POLARITY;
            settled_q <= (act_q == target_q);
        end
    end

    assign pwm_o     = pwm_q;
    assign settled_o = settled_q;

endmodule

// File: rtl/pwm_multi_ch.sv
// N-channel PWM: shared edge/center-aligned carrier, period/mode shadows
// reloaded at the period boundary, and per-channel write decode.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int               N           = 4,
    parameter int               WIDTH       = 16,
    parameter int               RAMP_STEP   = 0,
    parameter logic [N-1:0]     POLARITY    = '0,
    parameter logic [WIDTH-1:0] INIT_PERIOD = WIDTH'(9999),
    localparam int              CW          = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    input  logic             wr_en,
    input  logic [CW-1:0]    wr_ch,
    input  logic [WIDTH-1:0] wr_duty,
    output logic [N-1:0]     pwm_out,
    output logic [WIDTH-1:0] cnt,
    output logic             period_end,
    output logic [N-1:0]     settled
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d, period_q, period_d;
    logic             dir_q, dir_d;     // 1 = counting down
    logic             mode_q, mode_d;
    logic             pe_q;
    logic             pb;

    // Boundary = the tick whose next count is 0. In center mode with P=1
    // the turnaround at the top already lands on 0.
    always_comb begin
        pb = 1'b0;
        if (ce) begin
            if (period_q == '0) begin
                pb = 1'b1;
            end else if (mode_q == MODE_EDGE) begin
                pb = (cnt_q == period_q);
            end else begin
                pb = (cnt_q == ONE) && (dir_q || period_q == ONE);
            end
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        period_d = period_q;
        mode_d   = mode_q;
        if (pb) begin
            cnt_d    = '0;
            dir_d    = 1'b0;
            period_d = period;
            mode_d   = mode;
        end else if (ce) begin
            if (mode_q == MODE_EDGE) begin
                cnt_d = cnt_q + ONE;
            end else if (!dir_q && cnt_q == period_q) begin
                dir_d = 1'b1;
                cnt_d = cnt_q - ONE;
            end else if (dir_q) begin
                cnt_d = cnt_q - ONE;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            period_q <= INIT_PERIOD;
            mode_q   <= MODE_EDGE;
            pe_q     <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            pe_q     <= pb;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        pwm_chan #(
            .WIDTH     (WIDTH),
            .RAMP_STEP (RAMP_STEP),
            .POLARITY  (POLARITY[i])
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .pb_i      (pb),
            .cnt_i     (cnt_q),
            .wr_en_i   (wr_en && (wr_ch == CW'(i))),
            .wr_duty_i (wr_duty),
            .pwm_o     (pwm_out[i]),
            .settled_o (settled[i])
        );
    end

    assign cnt        = cnt_q;
    assign period_end = pe_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Directed bench: dut_a (N=4, no ramp, ch3 active-low) and dut_b
// (N=5, RAMP_STEP=2) share carrier inputs; each has its own write strobe.
module tb_pwm_multi_ch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        mode = 1'b0;
    logic [15:0] period = 16'd9;
    logic        wr_en_a = 1'b0;
    logic        wr_en_b = 1'b0;
    logic [2:0]  wr_ch = 3'd0;
    logic [15:0] wr_duty = 16'd0;

    logic [3:0]  pwm0, set0;
    logic [15:0] cnt0, cnt1;
    logic        pe0, pe1;
    logic [4:0]  pwm1, set1;

    int checks = 0;
    int errors = 0;
    int hi0 [4];
    int hi1 [5];
    int pe_cnt;
    logic st1_first;
    int n;

    always #5 clk = ~clk;

    pwm_multi_ch #(.N(4), .WIDTH(16), .RAMP_STEP(0), .POLARITY(4'b1000),
                   .INIT_PERIOD(16'd5)) dut_a (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .period(period),
        .wr_en(wr_en_a), .wr_ch(wr_ch[1:0]), .wr_duty(wr_duty),
        .pwm_out(pwm0), .cnt(cnt0), .period_end(pe0), .settled(set0));

    pwm_multi_ch #(.N(5), .WIDTH(16), .RAMP_STEP(2), .POLARITY(5'b00000),
                   .INIT_PERIOD(16'd5)) dut_b (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .period(period),
        .wr_en(wr_en_b), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .pwm_out(pwm1), .cnt(cnt1), .period_end(pe1), .settled(set1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        for (int c = 0; c < 4; c++) hi0[c] = 0;
        for (int c = 0; c < 5; c++) hi1[c] = 0;
        pe_cnt = 0;
    endtask

    task automatic measure(input int len);
        for (int k = 0; k < len; k++) begin
            tick();
            if (k == 0) st1_first = set1[0];
            for (int c = 0; c < 4; c++) if (pwm0[c]) hi0[c]++;
            for (int c = 0; c < 5; c++) if (pwm1[c]) hi1[c]++;
            if (pe0) pe_cnt++;
        end
    endtask

    task automatic to_pb(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (!pe0 && cycles < 40);
        chk("to_pb_reached", 32'(pe0), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin : stim
        int exp_cnt [8];
        int exp_pwm [8];
        int duties [4];
        exp_cnt = '{1, 2, 3, 4, 3, 2, 1, 0};
        exp_pwm = '{1, 1, 0, 0, 0, 0, 0, 1};
        duties  = '{3, 0, 12, 0};

        // Reset state
        tick();
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_pwm_a", 32'(pwm0), 32'h8);
        chk("rst_pwm_b", 32'(pwm1), 32'h0);
        chk("rst_pe", 32'(pe0), 32'd0);
        chk("rst_settled_a", 32'(set0), 32'hF);
        chk("rst_settled_b", 32'(set1), 32'h1F);

        // Load duties into dut_a, wait for the INIT_PERIOD boundary
        rst = 1'b0;
        wr_en_a = 1'b1;
        for (int c = 0; c < 4; c++) begin
            wr_ch = 3'(c);
            wr_duty = 16'(duties[c]);
            tick();
        end
        wr_en_a = 1'b0;
        to_pb(n);
        chk("pb_cnt_zero", 32'(cnt0), 32'd0);

        // Edge mode P=9: two full periods
        for (int w = 0; w < 2; w++) begin
            clr();
            measure(10);
            chk("edge_ch0_high3", hi0[0], 32'd3);
            chk("edge_ch1_duty0", hi0[1], 32'd0);
            chk("edge_ch2_duty12", hi0[2], 32'd10);
            chk("edge_ch3_pol", hi0[3], 32'd10);
            chk("edge_pe_once", pe_cnt, 32'd1);
            chk("edge_pe_at_end", 32'(pe0), 32'd1);
            chk("edge_cnt_at_pe", 32'(cnt0), 32'd0);
        end

        // Ramp up 0 -> 7 on dut_b ch0
        wr_en_b = 1'b1; wr_ch = 3'd0; wr_duty = 16'd7;
        tick();
        wr_en_b = 1'b0;
        to_pb(n);
        chk("ramp_settled_low", 32'(set1[0]), 32'd0);
        clr(); measure(10); chk("ramp_act2", hi1[0], 32'd2);
        clr(); measure(10); chk("ramp_act4", hi1[0], 32'd4);
        clr(); measure(10); chk("ramp_act6", hi1[0], 32'd6);
        chk("ramp_settled_at_pb", 32'(set1[0]), 32'd0);
        clr(); measure(10); chk("ramp_act7", hi1[0], 32'd7);
        chk("ramp_settled_next", 32'(st1_first), 32'd1);

        // Ramp down 7 -> 1
        wr_en_b = 1'b1; wr_duty = 16'd1;
        tick();
        wr_en_b = 1'b0;
        to_pb(n);
        clr(); measure(10); chk("rdown_act5", hi1[0], 32'd5);
        clr(); measure(10); chk("rdown_act3", hi1[0], 32'd3);
        clr(); measure(10); chk("rdown_act1", hi1[0], 32'd1);
        chk("rdown_settled", 32'(set1[0]), 32'd1);

        // Glitch-free update: write 8 while cnt=5
        clr();
        measure(5);
        wr_en_a = 1'b1; wr_ch = 3'd0; wr_duty = 16'd8;
        measure(1);
        wr_en_a = 1'b0;
        measure(4);
        chk("glitch_cur_period3", hi0[0], 32'd3);
        clr(); measure(10); chk("glitch_next_period8", hi0[0], 32'd8);

        // Write coinciding with the boundary applies one period later
        clr();
        measure(9);
        wr_en_a = 1'b1; wr_duty = 16'd2;
        measure(1);
        wr_en_a = 1'b0;
        chk("pbwr_pe", 32'(pe0), 32'd1);
        chk("pbwr_cur8", hi0[0], 32'd8);
        clr(); measure(10); chk("pbwr_still8", hi0[0], 32'd8);
        clr(); measure(10); chk("pbwr_now2", hi0[0], 32'd2);

        // Out-of-range channel on dut_b
        wr_en_b = 1'b1; wr_ch = 3'd5; wr_duty = 16'd9;
        tick();
        wr_en_b = 1'b0;
        tick();
        chk("badch_settled", 32'(set1), 32'h1F);

        // Center mode P=4, duty 2
        mode = 1'b1; period = 16'd4;
        wr_en_a = 1'b1; wr_ch = 3'd0; wr_duty = 16'd2;
        tick();
        wr_en_a = 1'b0;
        to_pb(n);
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 8; k++) begin
                tick();
                chk("ctr_cnt", 32'(cnt0), 32'(exp_cnt[k]));
                chk("ctr_pwm", 32'(pwm0[0]), 32'(exp_pwm[k]));
                chk("ctr_pe", 32'(pe0), (k == 7) ? 32'd1 : 32'd0);
            end
        end

        // Back to edge P=9, start a ramp 1 -> 9 on dut_b
        mode = 1'b0; period = 16'd9;
        wr_en_b = 1'b1; wr_ch = 3'd0; wr_duty = 16'd9;
        tick();
        wr_en_b = 1'b0;
        to_pb(n);
        for (int k = 0; k < 6; k++) tick();
        chk("pre_rst_cnt6", 32'(cnt0), 32'd6);

        // ce low holds the carrier
        ce = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        chk("ce_hold_cnt", 32'(cnt0), 32'd6);
        chk("ce_hold_pe", 32'(pe0), 32'd0);
        ce = 1'b1;

        // Reset mid-ramp, mid-period
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_cnt", 32'(cnt0), 32'd0);
        chk("midrst_pwm_a", 32'(pwm0), 32'h8);
        chk("midrst_pwm_b", 32'(pwm1), 32'h0);
        chk("midrst_settled_b", 32'(set1), 32'h1F);
        to_pb(n);
        chk("midrst_init_period", n, 32'd6);
        clr(); measure(10);
        chk("midrst_no_ramp", hi1[0], 32'd0);
        chk("midrst_ch3_pol", hi0[3], 32'd10);
        chk("midrst_settled_after", 32'(set1), 32'h1F);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
